// File: rtl/mrf_pkg.sv
// Shared definitions for the MRF event-stream transmitter.
//   K28_5 / EV_NULL : comma character and null event code
//   mrf_lane_t      : one 16-bit lane, {dbus byte, event byte}
//   mrf_params_ok   : elaboration-time legality check of the top-level parameters
package mrf_pkg;

  localparam logic [7:0] K28_5   = 8'hBC;
  localparam logic [7:0] EV_NULL = 8'h00;

  typedef struct packed {
    logic [7:0] dbus;
    logic [7:0] evt;
  } mrf_lane_t;

  function automatic bit mrf_params_ok(input int bytes, input int comma_period,
                                       input int fifo_depth);
    int lanes;
    lanes = bytes / 2;
    if (bytes != 2 && bytes != 4) return 1'b0;
    if (comma_period < lanes || (comma_period % lanes) != 0) return 1'b0;
    if (fifo_depth < 4 || (fifo_depth & (fifo_depth - 1)) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/mrf_event_fifo.sv
// Event-code queue: one write port, LANES-wide first-word-fall-through read.
//   clk, reset : clock and asynchronous active-high reset (flushes the queue)
//   push, din  : write one code (ignored when full)
//   pop_n      : number of head entries consumed this edge (0..LANES, <= count)
//   head       : the next LANES entries in FIFO order (valid up to count)
//   count,full : registered occupancy and its full flag
module mrf_event_fifo
  import mrf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LANES = 1,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [7:0]            din,
  input  logic [LW-1:0]         pop_n,
  output logic [LANES-1:0][7:0] head,
  output logic [LW-1:0]         count,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic          do_push;

  assign full    = (count_reg == LW'(DEPTH));
  assign count   = count_reg;
  assign do_push = push && !full;

  // Pointers wrap naturally because DEPTH is a power of two.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_head
      assign head[gi] = mem[rd_ptr_reg + AW'(gi)];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_reg + pop_n[AW-1:0];
      count_reg  <= count_reg + LW'(do_push) - pop_n;
    end
  end

endmodule

// File: rtl/mrf_frame_gen.sv
// MRF event-stream transmitter for the GTP TX user interface.
//   tx_clk, reset : sole clock; asynchronous active-high reset
//   ready         : GT TX reset done; low forces an all-zero idle word
//   ev_valid/ev_code/ev_ready : event queue write handshake (0x00 is dropped)
//   dbus          : distributed bus byte, copied into every lane
//   tx_data/tx_is_k : registered GT word and K-character flags
//   fifo_level    : queued events;  ev_sent : wrapping count of transmitted events
module mrf_frame_gen
  import mrf_pkg::*;
#(
  parameter  int BYTES        = 2,
  parameter  int COMMA_PERIOD = 4,
  parameter  int FIFO_DEPTH   = 16,
  parameter  int CNT_W        = 32,
  localparam int LANES        = BYTES / 2,
  localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                tx_clk,
  input  logic                reset,
  input  logic                ready,
  input  logic                ev_valid,
  input  logic [7:0]          ev_code,
  output logic                ev_ready,
  input  logic [7:0]          dbus,
  output logic [16*LANES-1:0] tx_data,
  output logic [BYTES-1:0]    tx_is_k,
  output logic [LW-1:0]       fifo_level,
  output logic [CNT_W-1:0]    ev_sent
);

  generate
    if (!mrf_params_ok(BYTES, COMMA_PERIOD, FIFO_DEPTH)) begin : g_bad_params
      $error("mrf_frame_gen: illegal BYTES, COMMA_PERIOD or FIFO_DEPTH");
    end
  endgenerate

  localparam int SW = $clog2(COMMA_PERIOD + 1);
  localparam logic [LW-1:0] LANES_W = LW'(LANES);

  logic                  rst_done_reg;
  logic [SW-1:0]         slot_cnt_reg;
  logic [SW-1:0]         slot_cnt_next;
  logic [SW-1:0]         slot_sum;
  mrf_lane_t [LANES-1:0] lane_reg;
  mrf_lane_t [LANES-1:0] lane_next;
  logic [BYTES-1:0]      is_k_reg;
  logic [BYTES-1:0]      is_k_next;
  logic [CNT_W-1:0]      ev_sent_reg;

  logic [LANES-1:0][7:0] head;
  logic [LW-1:0]         count;
  logic                  full;
  logic                  push;
  logic [LW-1:0]         pop_n;
  logic [LW-1:0]         avail_slots;
  logic                  comma;

  // rst_done_reg keeps ev_ready low until the first edge after reset release.
  assign ev_ready = rst_done_reg && !full;
  assign push     = ev_valid && ev_ready && (ev_code != EV_NULL);

  // slot_cnt is always a multiple of LANES below COMMA_PERIOD, so slot 0
  // can only ever fall on lane 0.
  assign comma = (slot_cnt_reg == '0);

  mrf_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LANES (LANES),
    .LW    (LW)
  ) u_fifo (
    .clk   (tx_clk),
    .reset (reset),
    .push  (push),
    .din   (ev_code),
    .pop_n (pop_n),
    .head  (head),
    .count (count),
    .full  (full)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] evt;
      if (gi == 0) begin : g_first
        assign evt = comma ? K28_5 : ((count != '0) ? head[0] : EV_NULL);
        assign is_k_next[0] = ready && comma;
      end else begin : g_rest
        localparam logic [LW-1:0] IDX    = LW'(gi);
        localparam logic [LW-1:0] IDX_M1 = LW'(gi - 1);
        // A comma on lane 0 shifts every later lane one FIFO entry earlier.
        assign evt = comma ? ((count > IDX_M1) ? head[gi-1] : EV_NULL)
                           : ((count > IDX)    ? head[gi]   : EV_NULL);
        assign is_k_next[2*gi] = 1'b0;
      end
      assign is_k_next[2*gi+1]  = 1'b0;
      assign lane_next[gi].dbus = ready ? dbus : 8'h00;
      assign lane_next[gi].evt  = ready ? evt  : 8'h00;
    end
  endgenerate

  always_comb begin
    avail_slots = comma ? (LANES_W - 1'b1) : LANES_W;
    pop_n       = '0;
    if (ready) pop_n = (count < avail_slots) ? count : avail_slots;
  end

  assign slot_sum      = slot_cnt_reg + SW'(LANES);
  assign slot_cnt_next = !ready ? '0 : ((slot_sum == SW'(COMMA_PERIOD)) ? '0 : slot_sum);

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      rst_done_reg <= 1'b0;
      slot_cnt_reg <= '0;
      lane_reg     <= '0;
      is_k_reg     <= '0;
      ev_sent_reg  <= '0;
    end else begin
      rst_done_reg <= 1'b1;
      slot_cnt_reg <= slot_cnt_next;
      lane_reg     <= lane_next;
      is_k_reg     <= is_k_next;
      ev_sent_reg  <= ev_sent_reg + CNT_W'(pop_n);
    end
  end

  assign tx_data    = lane_reg;
  assign tx_is_k    = is_k_reg;
  assign fifo_level = count;
  assign ev_sent    = ev_sent_reg;

endmodule

// File: tb/tb_mrf_frame_gen.sv
module tb_mrf_frame_gen;

  logic        clk;
  logic        rst;

  logic        a_rdy, a_valid, a_evr;
  logic [7:0]  a_code, a_dbus;
  logic [15:0] a_data;
  logic [1:0]  a_k;
  logic [4:0]  a_level;
  logic [31:0] a_sent;

  logic        b_rdy, b_valid, b_evr;
  logic [7:0]  b_code, b_dbus;
  logic [31:0] b_data;
  logic [3:0]  b_k;
  logic [4:0]  b_level;
  logic [31:0] b_sent;

  int passed = 0;
  int total  = 0;
  int n;
  logic [15:0] exp16;

  mrf_frame_gen #(.BYTES(2), .COMMA_PERIOD(4), .FIFO_DEPTH(16), .CNT_W(32)) u_a (
    .tx_clk(clk), .reset(rst), .ready(a_rdy), .ev_valid(a_valid), .ev_code(a_code),
    .ev_ready(a_evr), .dbus(a_dbus), .tx_data(a_data), .tx_is_k(a_k),
    .fifo_level(a_level), .ev_sent(a_sent)
  );

  mrf_frame_gen #(.BYTES(4), .COMMA_PERIOD(4), .FIFO_DEPTH(16), .CNT_W(32)) u_b (
    .tx_clk(clk), .reset(rst), .ready(b_rdy), .ev_valid(b_valid), .ev_code(b_code),
    .ev_ready(b_evr), .dbus(b_dbus), .tx_data(b_data), .tx_is_k(b_k),
    .fifo_level(b_level), .ev_sent(b_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_rdy = 0; a_valid = 0; a_code = 0; a_dbus = 0;
    b_rdy = 0; b_valid = 0; b_code = 0; b_dbus = 0;
    repeat (3) tick();

    chk("rst_a_data",  a_data,  0);
    chk("rst_a_k",     a_k,     0);
    chk("rst_a_sent",  a_sent,  0);
    chk("rst_a_level", a_level, 0);
    chk("rst_a_evr",   a_evr,   0);
    chk("rst_b_data",  b_data,  0);
    chk("rst_b_evr",   b_evr,   0);

    rst = 1'b0; a_rdy = 1'b1; a_dbus = 8'h5A;
    #1;
    chk("evr_before_first_edge", a_evr, 0);

    // Idle stream: one comma every 4 words for LANES=1.
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        chk("evr_after_release_a", a_evr, 1);
        chk("evr_after_release_b", b_evr, 1);
      end
      chk("idle_data", a_data, (i % 4 == 0) ? 16'h5ABC : 16'h5A00);
      chk("idle_k",    a_k,    (i % 4 == 0) ? 2'b01 : 2'b00);
    end

    // Back-to-back pushes of 01,02,03.
    a_valid = 1'b1; a_code = 8'h01;
    tick(); chk("push_w0", a_data, 16'h5ABC); chk("push_l0", a_level, 1);
    a_code = 8'h02;
    tick(); chk("push_w1", a_data, 16'h5A01); chk("push_l1", a_level, 1); chk("push_k1", a_k, 2'b00);
    a_code = 8'h03;
    tick(); chk("push_w2", a_data, 16'h5A02); chk("push_l2", a_level, 1);
    a_valid = 1'b0;
    tick(); chk("push_w3", a_data, 16'h5A03); chk("push_l3", a_level, 0); chk("push_sent", a_sent, 3);

    // Null code is accepted but never queued.
    a_valid = 1'b1; a_code = 8'h00;
    tick(); chk("null_level", a_level, 0); chk("null_w", a_data, 16'h5ABC);
    a_valid = 1'b0;
    tick(); chk("null_w2", a_data, 16'h5A00); chk("null_sent", a_sent, 3);

    // Fill the queue while the link is not ready.
    a_rdy = 1'b0; a_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_code = 8'(8'h10 + i);
      tick();
      chk("fill_evr", a_evr, (i < 15) ? 1'b1 : 1'b0);
    end
    chk("fill_data", a_data, 0);
    chk("fill_k", a_k, 0);
    a_code = 8'h99;
    tick(); chk("full_level", a_level, 16);
    a_valid = 1'b0; a_rdy = 1'b1;

    n = 0;
    for (int w = 0; w < 22; w++) begin
      tick();
      if (w % 4 == 0) exp16 = 16'h5ABC;
      else begin
        exp16 = {8'h5A, 8'(8'h10 + n)};
        n++;
      end
      chk("drain", a_data, exp16);
    end
    chk("drain_level", a_level, 0);
    chk("drain_sent", a_sent, 19);

    // Ready drop mid-stream.
    a_rdy = 1'b0; a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_code = 8'(8'h21 + i);
      tick();
    end
    chk("pause_data", a_data, 0);
    chk("pause_level", a_level, 4);
    a_valid = 1'b0; a_rdy = 1'b1;
    tick(); chk("mid_w0", a_data, 16'h5ABC); chk("mid_l0", a_level, 4);
    tick(); chk("mid_w1", a_data, 16'h5A21); chk("mid_l1", a_level, 3);
    a_rdy = 1'b0;
    tick(); chk("drop_data", a_data, 0); chk("drop_k", a_k, 0); chk("drop_level", a_level, 3);
    tick(); chk("drop_level2", a_level, 3);
    a_rdy = 1'b1;
    tick(); chk("resume_w0", a_data, 16'h5ABC); chk("resume_k0", a_k, 2'b01);
    tick(); chk("resume_w1", a_data, 16'h5A22);
    tick(); chk("resume_w2", a_data, 16'h5A23);
    tick(); chk("resume_w3", a_data, 16'h5A24);
    chk("resume_level", a_level, 0);
    chk("resume_sent", a_sent, 23);
    tick(); chk("resume_w4", a_data, 16'h5ABC);

    // Four-byte instance: two lanes per word.
    b_dbus = 8'hC3; b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_code = 8'(8'h31 + i);
      tick();
    end
    b_valid = 1'b0;
    chk("b_idle_data", b_data, 0);
    chk("b_level5", b_level, 5);
    b_rdy = 1'b1;
    tick(); chk("b_w0", b_data, 32'hC331C3BC); chk("b_k0", b_k, 4'b0001); chk("b_l0", b_level, 4);
    tick(); chk("b_w1", b_data, 32'hC333C332); chk("b_k1", b_k, 4'b0000); chk("b_l1", b_level, 2);
    tick(); chk("b_w2", b_data, 32'hC334C3BC); chk("b_k2", b_k, 4'b0001);
    tick(); chk("b_w3", b_data, 32'hC300C335); chk("b_sent", b_sent, 5); chk("b_l3", b_level, 0);
    tick(); chk("b_w4", b_data, 32'hC300C3BC); chk("b_k4", b_k, 4'b0001);

    // Asynchronous reset between clock edges.
    a_valid = 1'b1; a_code = 8'h41;
    tick(); chk("pre_rst_level", a_level, 1);
    a_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_a_data",  a_data,  0);
    chk("arst_a_k",     a_k,     0);
    chk("arst_a_level", a_level, 0);
    chk("arst_a_evr",   a_evr,   0);
    chk("arst_a_sent",  a_sent,  0);
    chk("arst_b_data",  b_data,  0);
    chk("arst_b_sent",  b_sent,  0);
    tick();
    rst = 1'b0; a_valid = 1'b1; a_code = 8'h00;
    tick(); chk("post_rst_w0", a_data, 16'h5ABC); chk("post_rst_evr", a_evr, 1);
    tick(); chk("post_rst_w1", a_data, 16'h5A00); chk("post_rst_level", a_level, 0);
    a_valid = 1'b0;
    tick(); chk("post_rst_sent", a_sent, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
